// File: rtl/fib_seq_pkg.sv
// Shared types and helpers for the second-order
// additive sequence engine.
package fib_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic MODE_NTH    = 1'b0;
  localparam logic MODE_STREAM = 1'b1;

  // All-ones value of a w-bit term (w <= 64)
  function automatic logic [63:0] sat_max(input int w);
    return {64{1'b1}} >> (64 - w);
  endfunction

endpackage

// File: rtl/fibonacci_seq_engine_fib_sat_adder.sv
// Term adder: wraps or clamps to all-ones on carry,
// carry always reported.
module fib_sat_adder #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);
  import fib_seq_pkg::*;

  localparam logic [WIDTH-1:0] MAX =
    WIDTH'(sat_max(WIDTH));

  logic [WIDTH:0] full;

  assign full    = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o = full[WIDTH];
  assign sum_o   = (SATURATE != 0 && carry_o) ?
                   MAX : full[WIDTH-1:0];

endmodule

// File: rtl/fibonacci_seq_engine.sv
// Second-order additive sequence engine with
// nth-term and back-pressured stream modes.
module fibonacci_seq_engine #(
  parameter int WIDTH    = 16,
  parameter int N_W      = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   n,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic             stream_en,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [N_W-1:0]   out_idx,
  output logic             out_last
);
  import fib_seq_pkg::*;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             a_ovf_q, a_ovf_d;
  logic             b_ovf_q, b_ovf_d;
  logic [N_W-1:0]   idx_q, idx_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             at_n;

  fib_sat_adder #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_add (
    .a_i     (a_q),
    .b_i     (b_q),
    .sum_o   (sum),
    .carry_o (carry)
  );

  assign at_n = (idx_q == n_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    a_ovf_d  = a_ovf_q;
    b_ovf_d  = b_ovf_q;
    idx_d    = idx_q;
    n_d      = n_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n;
          a_d     = seed0;
          b_d     = seed1;
          a_ovf_d = 1'b0;
          b_ovf_d = 1'b0;
          idx_d   = '0;
          ovf_d   = 1'b0;
          unique case (stream_en)
            MODE_NTH:    state_d = S_RUN;
            MODE_STREAM: state_d = S_STREAM;
          endcase
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (at_n) begin
          result_d = a_q;
          ovf_d    = a_ovf_q;
          state_d  = S_DONE;
        end else begin
          a_d     = b_q;
          a_ovf_d = b_ovf_q;
          b_d     = sum;
          b_ovf_d = carry | a_ovf_q | b_ovf_q;
          idx_d   = idx_q + N_W'(1);
        end
      end
      S_STREAM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          // Only accepted terms feed the sticky flag
          ovf_d = ovf_q | a_ovf_q;
          if (at_n) begin
            result_d = a_q;
            state_d  = S_DONE;
          end else begin
            a_d     = b_q;
            a_ovf_d = b_ovf_q;
            b_d     = sum;
            b_ovf_d = carry | a_ovf_q | b_ovf_q;
            idx_d   = idx_q + N_W'(1);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      a_ovf_q  <= 1'b0;
      b_ovf_q  <= 1'b0;
      idx_q    <= '0;
      n_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_ovf_q  <= a_ovf_d;
      b_ovf_q  <= b_ovf_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_valid = (state_q == S_STREAM);
  assign out_last  = out_valid && at_n;
  assign out_data  = a_q;
  assign out_idx   = idx_q;
  assign result    = result_q;
  assign overflow  = ovf_q;

endmodule
